contador_gray_param: RTL

// - Parametrised up/down Gray-code counter with a registered binary mirror; next generation of the 4-bit binary->Gray converter.
// - Generates the code sequence internally instead of decoding an external value.
// - Adds load, direction control, terminal-count and wrap flags.
// - Drives Gray-coded pointers and position encoders in the lab datapaths.

---
 rtl/contador_gray_param.sv | 58 +++++
 1 files changed

// File: rtl/contador_gray_param.sv
// Parametrised up/down Gray counter with registered binary mirror, load, tc and wrap flags.
// Define CONT_GRAY_SAT_EN for saturating mode (holds at the end value, no wrap pulse).
module contador_gray_param #(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] binario,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_BIN = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] step_bin;

  // tc marks the value from which the next step in the current direction wraps
  assign tc       = up ? (binario == '1) : (binario == '0);
  assign step_bin = up ? (binario + ONE) : (binario - ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      binario <= RST_BIN;
      gray    <= bin2gray(RST_BIN);
      wrap    <= 1'b0;
    end else if (load) begin
      binario <= load_bin;
      gray    <= bin2gray(load_bin);
      wrap    <= 1'b0;
    end else if (en) begin
`ifdef CONT_GRAY_SAT_EN
      if (!tc) begin
        binario <= step_bin;
        gray    <= bin2gray(step_bin);
      end
      wrap <= 1'b0;
`else
      binario <= step_bin;
      gray    <= bin2gray(step_bin);
      wrap    <= tc;
`endif
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule
